// File: rtl/react_timer.sv
// react_timer: random fore-period generator and millisecond reaction counter for the tester.
// Build option REACT_FALSE_START_EN: a press in WAIT before expiry restarts the fore-period.
module react_timer #(
  parameter int unsigned CLK_PER_MS   = 12000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned MAX_MS       = 999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] machine_state,
  input  logic       btn,
  output logic [9:0] react_time,
  output logic       signal_start,
  output logic       signal_react,
  output logic       signal_overflow,
  output logic       signal_cleared
);

  localparam logic [2:0] ST_WAIT     = 3'd1;
  localparam logic [2:0] ST_CLR_CNT1 = 3'd2;
  localparam logic [2:0] ST_START    = 3'd3;
  localparam logic [2:0] ST_CLR_CNT2 = 3'd5;

  localparam int unsigned PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [10:0] DELAY_BASE = 11'(MIN_DELAY_MS);
  localparam logic [9:0] MAX_CNT = 10'(MAX_MS);

  logic             btn_meta;
  logic             btn_sync;
  logic             btn_prev;
  logic             press;
  logic [15:0]      lfsr;
  logic [2:0]       state_d;
  logic [PRE_W-1:0] presc;
  logic [10:0]      delay_cnt;
  logic [10:0]      delay_load;
  logic [9:0]       ms_cnt;
  logic             in_wait;
  logic             in_start;
  logic             in_clr;
  logic             entry_wait;
  logic             false_start;
  logic             presc_clr;
  logic             presc_run;
  logic             ms_tick;

  assign press      = btn_sync & ~btn_prev;
  assign in_wait    = (machine_state == ST_WAIT);
  assign in_start   = (machine_state == ST_START);
  assign in_clr     = (machine_state == ST_CLR_CNT1) || (machine_state == ST_CLR_CNT2);
  assign entry_wait = in_wait && (state_d != ST_WAIT);
  assign delay_load = DELAY_BASE + {1'b0, lfsr[9:0]};

`ifdef REACT_FALSE_START_EN
  assign false_start = in_wait && !entry_wait && press && !signal_start;
`else
  assign false_start = 1'b0;
`endif

  assign presc_clr = entry_wait || in_clr || false_start;
  assign presc_run = in_wait || in_start;
  assign ms_tick   = presc_run && !presc_clr && (presc == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  // Taps 16,14,13,11; free-running so the fore-period depends on when WAIT is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= LFSR_SEED;
      state_d <= 3'd0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      state_d <= machine_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (presc_clr) begin
      presc <= '0;
    end else if (presc_run) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Expiry is flagged on the tick after delay_cnt has reached zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_cnt    <= '0;
      signal_start <= 1'b0;
    end else if (!in_wait) begin
      signal_start <= 1'b0;
    end else if (entry_wait || false_start) begin
      delay_cnt    <= delay_load;
      signal_start <= 1'b0;
    end else if (ms_tick) begin
      if (delay_cnt == 11'd0) begin
        signal_start <= 1'b1;
      end else begin
        delay_cnt <= delay_cnt - 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      signal_cleared <= 1'b0;
    end else begin
      signal_cleared <= in_clr;
    end
  end

  // A press in the same cycle as the timeout wins, so overflow stays low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_cnt          <= '0;
      react_time      <= '0;
      signal_react    <= 1'b0;
      signal_overflow <= 1'b0;
    end else begin
      if (in_clr) begin
        ms_cnt     <= '0;
        react_time <= '0;
      end
      if (!in_start) begin
        signal_react    <= 1'b0;
        signal_overflow <= 1'b0;
      end else if (!signal_react) begin
        if (press) begin
          react_time      <= ms_cnt;
          signal_react    <= 1'b1;
          signal_overflow <= 1'b0;
        end else if (ms_cnt >= MAX_CNT) begin
          react_time      <= MAX_CNT;
          signal_react    <= 1'b1;
          signal_overflow <= 1'b1;
        end else if (ms_tick) begin
          ms_cnt <= ms_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_react_timer.sv
// tb_react_timer: directed plus randomized sessions checked each cycle against a
// timestamp-based reference model of the fore-period and reaction measurement.
module tb_react_timer;
  localparam int CPM   = 4;
  localparam int MIN_D = 1000;
  localparam int MAXMS = 999;
  localparam logic [15:0] SEED = 16'h8400;  // low 10 bits zero: first WAIT right after reset gets 1000 ms
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CLR1 = 3'd2, S_START = 3'd3,
                         S_STORE = 3'd4, S_CLR2 = 3'd5, S_AVG = 3'd6, S_CMP = 3'd7;
`ifdef REACT_FALSE_START_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [2:0] machine_state = S_IDLE;
  logic [9:0] react_time;
  logic       signal_start, signal_react, signal_overflow, signal_cleared;

  react_timer #(
    .CLK_PER_MS(CPM), .MIN_DELAY_MS(MIN_D), .MAX_MS(MAXMS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .machine_state(machine_state), .btn(btn),
    .react_time(react_time), .signal_start(signal_start), .signal_react(signal_react),
    .signal_overflow(signal_overflow), .signal_cleared(signal_cleared)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  longint cyc = 0;

  // reference model state
  logic [15:0] m_lfsr = SEED;
  logic [2:0]  m_prev = S_IDLE;
  logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
  longint t_start = 0;
  longint s_entry = 0;
  bit done = 1'b0, ovf = 1'b0;
  logic [9:0] e_rt = '0;
  logic e_start = 1'b0, e_react = 1'b0, e_ovf = 1'b0, e_clr = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock cycle: check outputs of this cycle, apply inputs, predict next cycle.
  task automatic step(input logic [2:0] st, input logic b, input logic r);
    int ms;
    bit press, entry, cur_start;
    @(negedge clk);
    cmp("signal_start", 16'(signal_start), 16'(e_start));
    cmp("signal_react", 16'(signal_react), 16'(e_react));
    cmp("signal_overflow", 16'(signal_overflow), 16'(e_ovf));
    cmp("signal_cleared", 16'(signal_cleared), 16'(e_clr));
    cmp("react_time", 16'(react_time), 16'(e_rt));
    machine_state = st;
    btn = b;
    rst = r;
    cur_start = e_start;
    if (r) begin
      m_lfsr = SEED; m_prev = S_IDLE;
      b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
      done = 1'b0; ovf = 1'b0;
      e_rt = '0; e_start = 1'b0; e_react = 1'b0; e_ovf = 1'b0; e_clr = 1'b0;
    end else begin
      press = b2 && !b3;
      entry = (st != m_prev);
      e_start = 1'b0; e_clr = 1'b0; e_react = 1'b0; e_ovf = 1'b0;
      case (st)
        S_WAIT: begin
          if (entry || (FS_EN && press && !cur_start))
            t_start = cyc + CPM * (MIN_D + int'(m_lfsr[9:0]) + 1) + 1;
          e_start = (cyc + 1 >= t_start);
        end
        S_CLR1, S_CLR2: begin
          e_clr = 1'b1;
          e_rt = '0;
        end
        S_START: begin
          if (entry) begin
            s_entry = cyc; done = 1'b0; ovf = 1'b0;
          end
          if (!done) begin
            ms = int'((cyc - s_entry) / CPM);
            if (press) begin
              done = 1'b1; ovf = 1'b0;
              e_rt = 10'((ms > MAXMS) ? MAXMS : ms);
            end else if (ms >= MAXMS) begin
              done = 1'b1; ovf = 1'b1;
              e_rt = 10'(MAXMS);
            end
          end
          e_react = done;
          e_ovf = ovf;
        end
        default: ;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
      b3 = b2; b2 = b1; b1 = b;
      m_prev = st;
    end
    cyc++;
  endtask

  task automatic tail_states();
    repeat ($urandom_range(1, 4)) step(S_STORE, 1'($urandom_range(0, 1)), 1'b0);
    repeat ($urandom_range(1, 3)) step(S_CLR2, 1'b0, 1'b0);
    repeat ($urandom_range(1, 3)) step(S_AVG, 1'($urandom_range(0, 1)), 1'b0);
    repeat ($urandom_range(1, 3)) step(S_CMP, 1'b0, 1'b0);
    repeat ($urandom_range(1, 3)) step(S_IDLE, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    int kp, kend, plen;
    logic cur_b;

    // reset, then enter WAIT on the first cycle after release
    repeat (3) step(S_IDLE, 1'b0, 1'b1);
    step(S_WAIT, 1'b0, 1'b0);
    cmp("lit_reset_react_time", 16'(react_time), 16'd0);
    cmp("lit_reset_flags", 16'({signal_start, signal_react, signal_overflow, signal_cleared}), 16'd0);
    k = 0;
    while (!signal_start && k < 9000) begin
      step(S_WAIT, 1'b0, 1'b0);
      k++;
    end
    cmp_range("lit_fore_period_cycles", k, 4003, 4005);
    repeat (3) step(S_WAIT, 1'b0, 1'b0);
    step(S_CLR1, 1'b0, 1'b0);
    step(S_CLR1, 1'b0, 1'b0);
    cmp("lit_start_falls", 16'(signal_start), 16'd0);
    cmp("lit_cleared", 16'(signal_cleared), 16'd1);
    cmp("lit_clear_react_time", 16'(react_time), 16'd0);
    step(S_CLR1, 1'b0, 1'b0);

    // measured press at ms_cnt = 250, second press ignored
    for (int i = 0; i <= 1210; i++) begin
      step(S_START, ((i >= 1000 && i < 1010) || (i >= 1100 && i < 1110)), 1'b0);
      if (i == 1002) cmp("lit_react_latency_early", 16'(signal_react), 16'd0);
      if (i == 1003) begin
        cmp("lit_react_set", 16'(signal_react), 16'd1);
        cmp("lit_react_time_250", 16'(react_time), 16'd250);
        cmp("lit_no_overflow", 16'(signal_overflow), 16'd0);
      end
    end
    cmp("lit_second_press_ignored", 16'(react_time), 16'd250);
    step(S_STORE, 1'b0, 1'b0);
    step(S_STORE, 1'b0, 1'b0);
    cmp("lit_react_clears_press", 16'(signal_react), 16'd0);
    tail_states();

    // timeout with no press
    step(S_WAIT, 1'b0, 1'b0);
    repeat (300) step(S_WAIT, 1'b0, 1'b0);
    repeat (2) step(S_CLR1, 1'b0, 1'b0);
    for (int i = 0; i <= 4005; i++) begin
      step(S_START, 1'b0, 1'b0);
      if (i == 3996) cmp("lit_timeout_early", 16'(signal_react), 16'd0);
      if (i == 3997) begin
        cmp("lit_timeout_react", 16'(signal_react), 16'd1);
        cmp("lit_timeout_time", 16'(react_time), 16'd999);
        cmp("lit_timeout_overflow", 16'(signal_overflow), 16'd1);
      end
    end
    step(S_STORE, 1'b0, 1'b0);
    step(S_STORE, 1'b0, 1'b0);
    cmp("lit_timeout_react_clear", 16'(signal_react), 16'd0);
    cmp("lit_timeout_overflow_clear", 16'(signal_overflow), 16'd0);
    cmp("lit_timeout_time_held", 16'(react_time), 16'd999);
    tail_states();

    // false start: press about 500 ms into WAIT
    step(S_WAIT, 1'b0, 1'b0);
    k = 0;
    while (!signal_start && k < 14000) begin
      step(S_WAIT, (k >= 2000 && k < 2010), 1'b0);
      k++;
    end
`ifdef REACT_FALSE_START_EN
    cmp_range("lit_false_start_reload", k, 2002 + 4004, 2002 + 4 * 2024 + 2);
`else
    cmp_range("lit_false_start_ignored", k, 4004, 4 * 2024 + 2);
`endif
    repeat (2) step(S_CLR1, 1'b0, 1'b0);
    repeat (20) step(S_START, 1'b0, 1'b0);
    tail_states();

    // randomized sessions
    for (int r = 0; r < 5; r++) begin
      cur_b = 1'b0;
      step(S_WAIT, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        k = 0;
        while (!signal_start && k < 9000) begin
          step(S_WAIT, 1'b0, 1'b0);
          k++;
        end
        cmp("wait_expiry_within_bound", 16'(k < 9000), 16'd1);
        repeat ($urandom_range(0, 4)) step(S_WAIT, 1'b0, 1'b0);
      end else begin
        repeat ($urandom_range(20, 800)) begin
          if ($urandom_range(0, 63) == 0) cur_b = ~cur_b;
          step(S_WAIT, cur_b, 1'b0);
        end
      end
      repeat ($urandom_range(1, 4)) step(S_CLR1, 1'($urandom_range(0, 1)), 1'b0);
      kp = $urandom_range(5, 4300);
      plen = $urandom_range(3, 20);
      kend = (kp > 4000) ? 4010 : kp + $urandom_range(4, 40);
      for (int i = 0; i <= kend; i++) begin
        if (r == 2 && i == 600) begin
          step(S_START, 1'b0, 1'b1);
          step(S_IDLE, 1'b0, 1'b1);
          break;
        end
        step(S_START, ((i >= kp && i < kp + plen) || (i >= kp + 30 && i < kp + 35)), 1'b0);
      end
      tail_states();
    end

    repeat (3) step(S_IDLE, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
